// File: rtl/pwl_coef_loader.sv
// pwl_coef_loader: write-side companion to the PWL segment selector.
// Words are written into a shadow bank, the shadow breakpoints are checked for
// strict ascending order over three fixed cycles, and only an ordered table is
// copied into the active bank (all 14 words on one edge) that feeds the selector.
module pwl_coef_loader #(
  parameter int NUM_WORDS = 14,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              commit_req,
  output logic              busy,
  output logic              commit_done,
  output logic              commit_err,
  output logic              addr_err,
  output logic              table_valid,
  output logic [31:0]       x1,
  output logic [31:0]       x2,
  output logic [31:0]       x3,
  output logic [31:0]       x4,
  output logic [31:0]       m1,
  output logic [31:0]       m2,
  output logic [31:0]       m3,
  output logic [31:0]       m4,
  output logic [31:0]       m5,
  output logic [31:0]       c1,
  output logic [31:0]       c2,
  output logic [31:0]       c3,
  output logic [31:0]       c4,
  output logic [31:0]       c5
);

  typedef enum logic [2:0] {IDLE, CHK1, CHK2, CHK3, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shadow [NUM_WORDS];
  logic [31:0] active [NUM_WORDS];
  logic        ok;
  logic        wr_fire;
  logic        addr_bad;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        cmp_lt;

  // Sign-magnitude strict less-than, same ordering the selector uses:
  // -0 sorts below +0, equal words are never ordered.
  function automatic logic sm_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      return a[31];
    else if (!a[31])
      return a[30:0] < b[30:0];
    else
      return a[30:0] > b[30:0];
  endfunction

  assign wr_fire  = wr_valid && wr_ready;
  assign addr_bad = wr_addr > ADDR_W'(NUM_WORDS - 1);

  // Select the breakpoint pair examined in the current check cycle.
  always_comb begin
    cmp_a = shadow[2];
    cmp_b = shadow[3];
    case (state)
      CHK1: begin
        cmp_a = shadow[0];
        cmp_b = shadow[1];
      end
      CHK2: begin
        cmp_a = shadow[1];
        cmp_b = shadow[2];
      end
      default: begin
        cmp_a = shadow[2];
        cmp_b = shadow[3];
      end
    endcase
    cmp_lt = sm_lt(cmp_a, cmp_b);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs; commit requests outside IDLE are dropped.
  always_comb begin
    state_nxt   = state;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    commit_done = 1'b0;
    commit_err  = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (commit_req) state_nxt = CHK1;
      end
      CHK1: state_nxt = CHK2;
      CHK2: state_nxt = CHK3;
      CHK3: state_nxt = DONE;
      DONE: begin
        commit_done = ok;
        commit_err  = !ok;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow writes, order accumulation, atomic copy to the active bank and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      ok          <= 1'b0;
      table_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= wr_fire && addr_bad;
      if (wr_fire && !addr_bad) shadow[wr_addr] <= wr_data;
      case (state)
        IDLE: if (commit_req) ok <= 1'b1;
        CHK1, CHK2: ok <= ok && cmp_lt;
        CHK3: begin
          ok <= ok && cmp_lt;
          if (ok && cmp_lt) begin
            for (int i = 0; i < NUM_WORDS; i++) active[i] <= shadow[i];
            table_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x1 = active[0];
  assign x2 = active[1];
  assign x3 = active[2];
  assign x4 = active[3];
  assign m1 = active[4];
  assign m2 = active[5];
  assign m3 = active[6];
  assign m4 = active[7];
  assign m5 = active[8];
  assign c1 = active[9];
  assign c2 = active[10];
  assign c3 = active[11];
  assign c4 = active[12];
  assign c5 = active[13];

endmodule

// File: tb/tb_pwl_coef_loader.sv
// Directed + randomized bench for pwl_coef_loader with a word-level table model.
module tb_pwl_coef_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        busy, commit_done, commit_err, addr_err, table_valid;
  logic [31:0] x1, x2, x3, x4, m1, m2, m3, m4, m5, c1, c2, c3, c4, c5;
  logic [31:0] dut_act [14];

  int tests = 0;
  int fails = 0;

  logic [31:0] sh_m [14];
  logic [31:0] ac_m [14];
  logic        tv_m;

  always #5 clk = ~clk;

  pwl_coef_loader dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req), .busy(busy),
    .commit_done(commit_done), .commit_err(commit_err), .addr_err(addr_err),
    .table_valid(table_valid),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5)
  );

  assign dut_act[0] = x1;   assign dut_act[1] = x2;   assign dut_act[2] = x3;
  assign dut_act[3] = x4;   assign dut_act[4] = m1;   assign dut_act[5] = m2;
  assign dut_act[6] = m3;   assign dut_act[7] = m4;   assign dut_act[8] = m5;
  assign dut_act[9] = c1;   assign dut_act[10] = c2;  assign dut_act[11] = c3;
  assign dut_act[12] = c4;  assign dut_act[13] = c5;

  // Map a sign-magnitude word onto a signed integer line so that ordinary
  // integer comparison gives the table ordering (-0 lands just below +0).
  function automatic longint key(input logic [31:0] w);
    longint mag;
    mag = longint'(w[30:0]);
    return w[31] ? (-mag - 1) : mag;
  endfunction

  function automatic bit ordered();
    return key(sh_m[0]) < key(sh_m[1]) && key(sh_m[1]) < key(sh_m[2]) &&
           key(sh_m[2]) < key(sh_m[3]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_active();
    for (int i = 0; i < 14; i++) chk($sformatf("active%0d", i), dut_act[i], ac_m[i]);
    chk("table_valid", {31'b0, table_valid}, {31'b0, tv_m});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 14; i++) begin
      sh_m[i] = '0;
      ac_m[i] = '0;
    end
    tv_m = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    if (a < 4'd14) sh_m[a] = d;
    chk($sformatf("addr_err@%0d", a), {31'b0, addr_err}, {31'b0, (a > 4'd13)});
  endtask

  task automatic do_commit(input bit same_wr, input bit hold, input bit pulse2,
                           input logic [3:0] a, input logic [31:0] d);
    bit exp_ok;
    commit_req = 1'b1;
    if (same_wr) begin
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
    end
    tick();
    commit_req = 1'b0;
    wr_valid   = 1'b0;
    if (same_wr) sh_m[a] = d;
    exp_ok = ordered();
    if (hold) begin
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
    end
    for (int c = 1; c <= 3; c++) begin
      chk("busy_chk", {31'b0, busy}, 32'd1);
      chk("wr_ready_chk", {31'b0, wr_ready}, 32'd0);
      chk("pulse_early", {30'b0, commit_done, commit_err}, 32'd0);
      check_active();
      if (pulse2 && c == 2) commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
    end
    if (exp_ok) begin
      for (int i = 0; i < 14; i++) ac_m[i] = sh_m[i];
      tv_m = 1'b1;
    end
    chk("commit_done", {31'b0, commit_done}, {31'b0, exp_ok});
    chk("commit_err", {31'b0, commit_err}, {31'b0, !exp_ok});
    chk("busy_done", {31'b0, busy}, 32'd1);
    check_active();
    tick();
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("wr_ready_idle", {31'b0, wr_ready}, 32'd1);
    chk("pulse_after", {30'b0, commit_done, commit_err}, 32'd0);
    if (hold) begin
      tick();
      wr_valid = 1'b0;
      sh_m[a] = d;
    end
    if (pulse2) begin
      tick();
      chk("req_in_chk2_ignored", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xs [4];
    logic [31:0] t;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // reset state
    check_active();
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_pulses", {29'b0, commit_done, commit_err, addr_err}, 32'd0);

    // good table
    wr(4'd0, 32'hBF800000); wr(4'd1, 32'h3F000000);
    wr(4'd2, 32'h3F800000); wr(4'd3, 32'h40000000);
    for (int i = 4; i <= 8; i++) wr(4'(i), 32'h40400000);
    for (int i = 9; i <= 13; i++) wr(4'(i), 32'h3F000000);
    check_active();
    do_commit(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("good_x3", x3, 32'h3F800000);
    chk("good_tv", {31'b0, table_valid}, 32'd1);

    // bad order: x3 = 3.0 > x4 = 2.0
    wr(4'd2, 32'h40400000);
    do_commit(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("bad_x3_kept", x3, 32'h3F800000);

    // -0 < +0 passes, -0 == -0 fails
    wr(4'd0, 32'h80000000); wr(4'd1, 32'h00000000);
    wr(4'd2, 32'h3F800000); wr(4'd3, 32'h40000000);
    do_commit(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("zero_x1", x1, 32'h80000000);
    wr(4'd1, 32'h80000000);
    do_commit(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("eq_x2_kept", x2, 32'h00000000);

    // out-of-range addresses
    wr(4'd14, 32'hDEADBEEF);
    wr(4'd15, 32'h12345678);
    check_active();
    wr(4'd1, 32'h00000000);
    chk("addr_err_clear", {31'b0, addr_err}, 32'd0);

    // wr_valid held through a check: x4 = -2.0 must not be taken before T+5
    do_commit(1'b0, 1'b1, 1'b0, 4'd3, 32'hC0000000);
    chk("hold_x4_active", x4, 32'h40000000);
    // write and commit on the same edge repair x4; commit_req pulsed in CHK2
    do_commit(1'b1, 1'b0, 1'b1, 4'd3, 32'h40800000);
    chk("same_edge_x4", x4, 32'h40800000);

    // reset in CHK2 of a good commit
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_active();
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, commit_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", {30'b0, busy, commit_done}, 32'd0);
      chk("post_rst_ready", {31'b0, wr_ready}, 32'd1);
    end
    check_active();

    // randomized tables
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 4; i++) xs[i] = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        for (int p = 0; p < 3; p++)
          for (int q = 0; q < 3 - p; q++)
            if (key(xs[q]) > key(xs[q+1])) begin
              t = xs[q]; xs[q] = xs[q+1]; xs[q+1] = t;
            end
      end
      for (int i = 0; i < 4; i++) wr(4'(i), xs[i]);
      for (int k = 0; k < 3; k++) wr(4'($urandom_range(4, 13)), $urandom());
      if ($urandom_range(0, 3) == 0) wr(4'($urandom_range(14, 15)), $urandom());
      do_commit(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
